// File: rtl/phase_comp_pkg.sv
// Shared types and sizing helpers for the phase-compensator controller.
package phase_comp_pkg;

  typedef enum logic [1:0] {
    H_IDLE,
    H_ACK,
    H_WAIT
  } host_st_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEFAULT = idx_width(16);

  // Vote counter must hold +/-2^FILT as a signed value.
  function automatic int vote_width(input int filt);
    return filt + 2;
  endfunction

  function automatic logic [63:0] mid_code(input int w);
    return 64'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/phase_comp_step_unit.sv
// Combinational vote accumulate, threshold detect and saturating code step
// for the currently selected channel.
module phase_comp_step_unit
  import phase_comp_pkg::*;
#(
  parameter int W    = 8,
  parameter int FILT = 2
) (
  input  logic signed [vote_width(FILT)-1:0] vote_i,
  input  logic        [W-1:0]                code_i,
  input  logic                               pd_i,
  output logic signed [vote_width(FILT)-1:0] vote_o,
  output logic        [W-1:0]                code_o,
  output logic                               sat_o
);

  localparam int VW = vote_width(FILT);
  localparam logic signed [VW-1:0] ONE  = VW'(1);
  localparam logic signed [VW-1:0] THR  = VW'(1 << FILT);
  localparam logic signed [VW-1:0] NTHR = -THR;
  localparam logic        [W-1:0]  CMAX = '1;
  localparam logic        [W-1:0]  CMIN = '0;

  logic signed [VW-1:0] vsum;

  always_comb begin
    vsum   = pd_i ? (vote_i - ONE) : (vote_i + ONE);
    vote_o = vsum;
    code_o = code_i;
    sat_o  = 1'b0;
    // The vote clears on threshold even when the step itself is blocked.
    if (vsum == THR) begin
      vote_o = '0;
      if (code_i == CMAX) sat_o = 1'b1;
      else                code_o = code_i + W'(1);
    end else if (vsum == NTHR) begin
      vote_o = '0;
      if (code_i == CMIN) sat_o = 1'b1;
      else                code_o = code_i - W'(1);
    end
  end

endmodule

// File: rtl/phase_comp_ctrl_param.sv
// Round-robin phase-compensator code controller with vote filtering,
// saturation flags and a single-beat host register port.
module phase_comp_ctrl_param
  import phase_comp_pkg::*;
#(
  parameter int NCH  = 16,
  parameter int W    = 8,
  parameter int FILT = 2
) (
  input  logic                      clk,
  input  logic                      resetb,
  input  logic                      enable,
  input  logic [NCH-1:0]            pd_in,
  input  logic [NCH-1:0]            freeze,
  input  logic                      host_req,
  input  logic                      host_wr,
  input  logic [idx_width(NCH)-1:0] host_addr,
  input  logic [W-1:0]              host_wdata,
  output logic                      host_ack,
  output logic [W-1:0]              host_rdata,
  output logic [NCH*W-1:0]          code_out,
  output logic [NCH-1:0]            sat,
  input  logic                      sat_clr
);

  localparam int AW = idx_width(NCH);
  localparam int VW = vote_width(FILT);
  localparam logic [W-1:0]  CODE_RST = W'(mid_code(W));
  localparam logic [AW:0]   NCH_L    = (AW+1)'(NCH);
  localparam logic [AW-1:0] SEL_LAST = AW'(NCH - 1);

  logic [NCH-1:0]       pd_q;
  logic [NCH-1:0]       sat_q, sat_d;
  logic [AW-1:0]        sel_q, sel_d;
  logic [W-1:0]         code_q [NCH];
  logic [W-1:0]         code_d [NCH];
  logic signed [VW-1:0] vote_q [NCH];
  logic signed [VW-1:0] vote_d [NCH];
  host_st_e             hst_q, hst_d;
  logic [W-1:0]         rdata_q, rdata_d;

  logic                 grant, addr_ok, wr_hit, visit;
  logic signed [VW-1:0] step_vote;
  logic [W-1:0]         step_code;
  logic                 step_sat;

  phase_comp_step_unit #(
    .W    (W),
    .FILT (FILT)
  ) u_step (
    .vote_i (vote_q[sel_q]),
    .code_i (code_q[sel_q]),
    .pd_i   (pd_q[sel_q]),
    .vote_o (step_vote),
    .code_o (step_code),
    .sat_o  (step_sat)
  );

  // Host handshake: grant on the edge leaving IDLE, then wait for req to drop.
  always_comb begin
    hst_d = hst_q;
    grant = 1'b0;
    case (hst_q)
      H_IDLE: if (host_req) begin
        hst_d = H_ACK;
        grant = 1'b1;
      end
      H_ACK:   hst_d = host_req ? H_WAIT : H_IDLE;
      H_WAIT:  if (!host_req) hst_d = H_IDLE;
      default: hst_d = H_IDLE;
    endcase
  end

  always_comb begin
    addr_ok = ({1'b0, host_addr} < NCH_L);
    wr_hit  = grant & host_wr & addr_ok;
    visit   = enable & ~freeze[sel_q] & ~(wr_hit & (host_addr == sel_q));

    sel_d = sel_q;
    if (enable) sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + AW'(1);

    code_d = code_q;
    vote_d = vote_q;
    if (visit) begin
      code_d[sel_q] = step_code;
      vote_d[sel_q] = step_vote;
    end
    if (wr_hit) begin
      code_d[host_addr] = host_wdata;
      vote_d[host_addr] = '0;
    end

    sat_d = sat_clr ? '0 : sat_q;
    if (visit && step_sat) sat_d[sel_q] = 1'b1;

    rdata_d = '0;
    if (grant && !host_wr && addr_ok) rdata_d = code_q[host_addr];
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      pd_q    <= '0;
      sel_q   <= '0;
      sat_q   <= '0;
      hst_q   <= H_IDLE;
      rdata_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        code_q[k] <= CODE_RST;
        vote_q[k] <= '0;
      end
    end else begin
      pd_q    <= pd_in;
      sel_q   <= sel_d;
      sat_q   <= sat_d;
      hst_q   <= hst_d;
      rdata_q <= rdata_d;
      for (int k = 0; k < NCH; k++) begin
        code_q[k] <= code_d[k];
        vote_q[k] <= vote_d[k];
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_out
    assign code_out[k*W +: W] = code_q[k];
  end

  assign host_ack   = (hst_q == H_ACK);
  assign host_rdata = rdata_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_phase_comp_ctrl_param.sv
// Directed bench for phase_comp_ctrl_param: three instances covering FILT=0,
// FILT=2 and a non-power-of-two channel count.
module tb_phase_comp_ctrl_param;

  logic clk;
  logic resetb;
  int   tests;
  int   fails;

  // Instance A: NCH=16, W=8, FILT=0
  logic         a_en, a_req, a_wr, a_ack, a_sc;
  logic [15:0]  a_pd, a_frz, a_sat;
  logic [3:0]   a_addr;
  logic [7:0]   a_wd, a_rd;
  logic [127:0] a_code;

  // Instance B: NCH=16, W=8, FILT=2
  logic         b_en, b_req, b_wr, b_ack, b_sc;
  logic [15:0]  b_pd, b_frz, b_sat;
  logic [3:0]   b_addr;
  logic [7:0]   b_wd, b_rd;
  logic [127:0] b_code;

  // Instance C: NCH=12, W=8, FILT=2
  logic         c_en, c_req, c_wr, c_ack, c_sc;
  logic [11:0]  c_pd, c_frz, c_sat;
  logic [3:0]   c_addr;
  logic [7:0]   c_wd, c_rd;
  logic [95:0]  c_code;

  phase_comp_ctrl_param #(.NCH(16), .W(8), .FILT(0)) dut_a (
    .clk(clk), .resetb(resetb), .enable(a_en), .pd_in(a_pd), .freeze(a_frz),
    .host_req(a_req), .host_wr(a_wr), .host_addr(a_addr), .host_wdata(a_wd),
    .host_ack(a_ack), .host_rdata(a_rd), .code_out(a_code), .sat(a_sat),
    .sat_clr(a_sc)
  );

  phase_comp_ctrl_param #(.NCH(16), .W(8), .FILT(2)) dut_b (
    .clk(clk), .resetb(resetb), .enable(b_en), .pd_in(b_pd), .freeze(b_frz),
    .host_req(b_req), .host_wr(b_wr), .host_addr(b_addr), .host_wdata(b_wd),
    .host_ack(b_ack), .host_rdata(b_rd), .code_out(b_code), .sat(b_sat),
    .sat_clr(b_sc)
  );

  phase_comp_ctrl_param #(.NCH(12), .W(8), .FILT(2)) dut_c (
    .clk(clk), .resetb(resetb), .enable(c_en), .pd_in(c_pd), .freeze(c_frz),
    .host_req(c_req), .host_wr(c_wr), .host_addr(c_addr), .host_wdata(c_wd),
    .host_ack(c_ack), .host_rdata(c_rd), .code_out(c_code), .sat(c_sat),
    .sat_clr(c_sc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    resetb = 1'b0;
    a_en = 0; a_req = 0; a_wr = 0; a_sc = 0; a_pd = '0; a_frz = '0; a_addr = '0; a_wd = '0;
    b_en = 0; b_req = 0; b_wr = 0; b_sc = 0; b_pd = '0; b_frz = '0; b_addr = '0; b_wd = '0;
    c_en = 0; c_req = 0; c_wr = 0; c_sc = 0; c_pd = '0; c_frz = '0; c_addr = '0; c_wd = '0;

    // Reset state
    tick(2);
    chk("rst_code0", a_code[0*8 +: 8], 8'd128);
    chk("rst_code15", a_code[15*8 +: 8], 8'd128);
    chk("rst_sat", a_sat, 16'h0);
    chk("rst_ack", a_ack, 1'b0);
    chk("rst_rdata", a_rd, 8'h0);
    chk("rst_c_code11", c_code[11*8 +: 8], 8'd128);
    resetb = 1'b1;

    // FILT=0, pd=0: one step up per visit
    a_en = 1;
    tick(16);
    chk("f0_r1_ch0", a_code[0*8 +: 8], 8'd129);
    chk("f0_r1_ch15", a_code[15*8 +: 8], 8'd129);
    tick(1);
    chk("f0_wrap_ch0", a_code[0*8 +: 8], 8'd130);
    chk("f0_wrap_ch1", a_code[1*8 +: 8], 8'd129);
    tick(15);
    chk("f0_r2_ch15", a_code[15*8 +: 8], 8'd130);
    chk("f0_r2_ch7", a_code[7*8 +: 8], 8'd130);
    a_en = 0;
    tick(5);
    chk("f0_hold_ch0", a_code[0*8 +: 8], 8'd130);

    // Host write 255 to ch5 then saturation
    a_req = 1; a_wr = 1; a_addr = 4'd5; a_wd = 8'd255;
    tick(1);
    chk("wr5_ack", a_ack, 1'b1);
    chk("wr5_code", a_code[5*8 +: 8], 8'd255);
    a_req = 0; a_wr = 0;
    tick(1);
    chk("wr5_ack_drop", a_ack, 1'b0);
    a_en = 1;
    tick(6);
    a_en = 0;
    chk("sat5_code", a_code[5*8 +: 8], 8'd255);
    chk("sat5_flag", a_sat, 16'h0020);
    chk("sat5_ch0", a_code[0*8 +: 8], 8'd131);
    a_sc = 1;
    tick(1);
    a_sc = 0;
    chk("satclr", a_sat, 16'h0);
    a_en = 1;
    tick(16);
    chk("sat5_again", a_sat, 16'h0020);
    chk("sat5_code2", a_code[5*8 +: 8], 8'd255);
    a_sc = 1;
    tick(1);
    a_sc = 0;
    chk("satclr2", a_sat, 16'h0);
    tick(14);
    a_sc = 1;
    tick(1);
    a_sc = 0;
    a_en = 0;
    chk("sat_set_wins", a_sat, 16'h0020);
    chk("ch0_133", a_code[0*8 +: 8], 8'd133);
    chk("ch6_132", a_code[6*8 +: 8], 8'd132);

    // Host write to ch7 in the cycle sel=7
    a_en = 1;
    tick(1);
    a_req = 1; a_wr = 1; a_addr = 4'd7; a_wd = 8'h3C;
    tick(1);
    a_en = 0; a_req = 0; a_wr = 0;
    chk("wr7_ack", a_ack, 1'b1);
    chk("wr7_code", a_code[7*8 +: 8], 8'h3C);
    chk("wr7_ch6", a_code[6*8 +: 8], 8'd133);
    tick(1);
    chk("wr7_ack_1cyc", a_ack, 1'b0);
    a_req = 1; a_addr = 4'd7;
    tick(1);
    chk("rd7_ack", a_ack, 1'b1);
    chk("rd7_data", a_rd, 8'h3C);
    tick(1);
    chk("rd7_held_noack1", a_ack, 1'b0);
    tick(1);
    chk("rd7_held_noack2", a_ack, 1'b0);
    a_req = 0;
    tick(1);
    a_req = 1;
    tick(1);
    chk("rd7_reack", a_ack, 1'b1);
    chk("rd7_reack_data", a_rd, 8'h3C);
    a_req = 0;
    tick(1);

    // freeze ch2 for 64 cycles
    a_frz = 16'h0004; a_en = 1;
    tick(64);
    chk("frz_ch2", a_code[2*8 +: 8], 8'd133);
    chk("frz_ch3", a_code[3*8 +: 8], 8'd137);
    chk("frz_ch7", a_code[7*8 +: 8], 8'h40);

    // Async reset mid-run, with a write in flight
    resetb = 1'b0;
    a_req = 1; a_wr = 1; a_addr = 4'd0; a_wd = 8'h11;
    #2;
    chk("arst_ch0", a_code[0*8 +: 8], 8'd128);
    chk("arst_ch3", a_code[3*8 +: 8], 8'd128);
    chk("arst_ack", a_ack, 1'b0);
    tick(1);
    chk("arst_nowrite", a_code[0*8 +: 8], 8'd128);
    resetb = 1'b1;
    a_req = 0; a_wr = 0;
    tick(1);
    chk("resume_ch0", a_code[0*8 +: 8], 8'd129);
    chk("resume_ch1", a_code[1*8 +: 8], 8'd128);
    a_en = 0; a_frz = '0;

    // FILT=2: pd[3]=1 steps down once per 4 visits
    b_pd = 16'h0008;
    tick(1);
    b_en = 1;
    tick(48);
    chk("f2_3v_ch3", b_code[3*8 +: 8], 8'd128);
    chk("f2_3v_ch0", b_code[0*8 +: 8], 8'd128);
    tick(16);
    chk("f2_4v_ch3", b_code[3*8 +: 8], 8'd127);
    chk("f2_4v_ch0", b_code[0*8 +: 8], 8'd129);
    for (int i = 0; i < 8; i++) begin
      b_pd[4] = (i % 2 == 0);
      tick(16);
    end
    b_en = 0;
    chk("f2_alt_ch4", b_code[4*8 +: 8], 8'd129);
    chk("f2_ch3_125", b_code[3*8 +: 8], 8'd125);
    chk("f2_ch0_131", b_code[0*8 +: 8], 8'd131);
    chk("f2_nosat", b_sat, 16'h0);

    // NCH=12: wrap at 11 and out-of-range host access
    c_en = 1;
    tick(48);
    c_en = 0;
    chk("n12_ch0", c_code[0*8 +: 8], 8'd129);
    chk("n12_ch11", c_code[11*8 +: 8], 8'd129);
    c_req = 1; c_wr = 0; c_addr = 4'd0;
    tick(1);
    chk("n12_rd0_ack", c_ack, 1'b1);
    chk("n12_rd0_data", c_rd, 8'd129);
    c_req = 0;
    tick(1);
    c_req = 1; c_addr = 4'd13;
    tick(1);
    chk("n12_rd13_ack", c_ack, 1'b1);
    chk("n12_rd13_data", c_rd, 8'h0);
    c_req = 0;
    tick(1);
    c_req = 1; c_wr = 1; c_addr = 4'd13; c_wd = 8'h55;
    tick(1);
    chk("n12_wr13_ack", c_ack, 1'b1);
    c_req = 0; c_wr = 0;
    tick(1);
    chk("n12_wr13_nochg", c_code, {12{8'h81}});
    chk("n12_sat", c_sat, 12'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/phase_comp_ctrl_param.md
PHASE_COMP_CTRL_PARAM -- requirements
Module: phase_comp_ctrl_param

Interface
REQ-001 Parameter NCH, default 16, number of phase-compensator channels (2..64, need not be a power of two).
REQ-002 Parameter W, default 8, width of each channel control code.
REQ-003 Parameter FILT, default 2, vote-filter depth; step threshold THR = 2^FILT, and FILT=0 means step on every visit.
REQ-004 clk  input  1  clock.
REQ-005 resetb  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  round-robin update enable.
REQ-007 pd_in  input  NCH  phase-detector outputs (1 = down, 0 = up), one bit per channel.
REQ-008 freeze  input  NCH  per-channel update inhibit.
REQ-009 host_req  input  1  host access request.
REQ-010 host_wr  input  1  1 = write, 0 = read.
REQ-011 host_addr  input  clog2(NCH)  channel index.
REQ-012 host_wdata  input  W  write data.
REQ-013 host_ack  output  1  one-cycle access acknowledge.
REQ-014 host_rdata  output  W  read data, valid while host_ack is high.
REQ-015 code_out  output  NCH*W  flattened channel codes; channel k occupies bits [k*W +: W].
REQ-016 sat  output  NCH  sticky per-channel saturation flags.
REQ-017 sat_clr  input  1  clears all sat flags.

Function
REQ-018 pd_in SHALL be registered into pd_q on every clk edge, independent of enable.
REQ-019 Scheduler index sel SHALL increment by 1 per clk while enable=1, wrap from NCH-1 to 0, and hold while enable=0.
REQ-020 Each clk with enable=1, channel sel SHALL be visited; the visit is skipped when freeze[sel]=1 or when a host write to sel occurs in the same cycle.
REQ-021 On a visit, vote[sel] (signed, FILT+2 bits) SHALL add -1 if pd_q[sel]=1 and +1 if pd_q[sel]=0.
REQ-022 When the updated vote reaches +THR, code[sel] SHALL increment and vote[sel] SHALL clear; at -THR, code[sel] SHALL decrement and vote[sel] SHALL clear.
REQ-023 Code arithmetic SHALL saturate at 0 and 2^W-1, with no wrap-around.
REQ-024 A step that is blocked by saturation SHALL set sat[sel]; sat_clr SHALL clear all sat flags, and a set event coinciding with sat_clr SHALL win.
REQ-025 A code change SHALL appear on code_out on the clk edge at which the visit occurs.
REQ-026 Host handshake: host_ack SHALL rise on the clk edge after host_req is sampled high, last exactly one cycle, and not re-assert until host_req has been low for at least one cycle.
REQ-027 A host write SHALL commit wdata to code[addr] and clear vote[addr] on the ack edge, and SHALL take priority over a same-cycle visit.
REQ-028 A host read SHALL return code[addr] as sampled on the ack edge.
REQ-029 A host_addr value >= NCH SHALL be acked, SHALL be ignored for writes, and SHALL return 0 for reads.

Reset
REQ-030 While resetb=0, the following SHALL be held: code=2^(W-1) (mid-scale); vote=0; sel=0; pd_q=0; sat=0; host_ack=0; host_rdata=0.
REQ-031 Reset asserted mid-access SHALL abort the access with no write.
REQ-032 Operation SHALL resume on the first clk after reset release.

Structure
REQ-033 The shared package phase_comp_pkg SHALL hold the mid-scale reset-code function, the vote-width function, and the clog2-based index-width constant.
REQ-034 One sub-module, phase_comp_step_unit, SHALL hold the combinational vote/threshold/saturating-step datapath, shared by all channels through the sel multiplexer.

Verification (NCH=16, W=8)
REQ-035 FILT=0, enable=1, pd_in=0 for 32 cycles: every code goes 128 -> 130, and sel wraps 15 -> 0.
REQ-036 FILT=2, pd_in[3]=1 held: code[3] decrements once per 4 visits (128 -> 127 after 4 visits); a pd pattern alternating 1/0 never steps.
REQ-037 Host write of 255 to channel 5 with pd_in[5]=0, then 2 visits: code stays 255 and sat[5]=1; sat_clr clears it.
REQ-038 Host write to channel 7 issued in the same cycle sel=7: the written value wins; host_ack is high for one cycle; a read then returns the written value.
REQ-039 freeze[2]=1 for 64 cycles: code[2] and vote[2] are unchanged; resetb pulsed low mid-run returns all codes to 128 asynchronously.
REQ-040 NCH=12: sel wraps 11 -> 0; a host access with addr=13 is acked, returns rdata=0, and changes no state.
